// File: rtl/cp0_regfile.sv
// cp0_regfile: Coprocessor-0 architectural register file.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC. MTC0 writes arrive from WB and
// exception/ERET commits from MEM. The block runs the Count/Compare timer and raises the
// interrupt-pending flag.
//
// Optional feature macro: CP0_TIMER_EN
//   defined   - Count/Compare timer implemented (divider, TI, Cause.IP[7] timer OR-in)
//   undefined - Count/Compare read 0, writes to them are ignored, TI is constant 0
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   hw_int[5:0]      external level interrupt lines, sampled every cycle
//   write_flag/addr/data   committed MTC0 (sel 0)
//   read_addr        MFC0 register number; read_data is a combinational read
//   exc_flag, exc_code, exc_pc, exc_delayslot, exc_badvaddr   exception commit
//   eret_flag        ERET commit
//   status, cause, epc     registered architectural registers
//   timer_int        Cause.TI
//   int_pending      enabled, unmasked interrupt present and not at exception level
module cp0_regfile #(
    parameter int unsigned COUNT_DIV  = 2,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hw_int,
    input  logic        write_flag,
    input  logic [4:0]  write_addr,
    input  logic [31:0] write_data,
    input  logic [4:0]  read_addr,
    input  logic        exc_flag,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_delayslot,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_flag,
    output logic [31:0] read_data,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc,
    output logic        timer_int,
    output logic        int_pending
);

    localparam logic [4:0] RegBadVAddr = 5'd8;
    localparam logic [4:0] RegCount    = 5'd9;
    localparam logic [4:0] RegCompare  = 5'd11;
    localparam logic [4:0] RegStatus   = 5'd12;
    localparam logic [4:0] RegCause    = 5'd13;
    localparam logic [4:0] RegEpc      = 5'd14;

    localparam logic [31:0] StatusBev   = 32'h0040_0000;
    localparam logic [31:0] StatusWMask = 32'h0000_FF03;

    if (COUNT_DIV < 1) begin : g_bad_count_div
        $error("cp0_regfile: COUNT_DIV must be >= 1");
    end

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_rd, compare_rd;
    logic        ti_d;
    logic        exl_merged;

    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    always_comb begin
        wr_count   = write_flag && (write_addr == RegCount);
        wr_compare = write_flag && (write_addr == RegCompare);
        wr_status  = write_flag && (write_addr == RegStatus);
        wr_cause   = write_flag && (write_addr == RegCause);
        wr_epc     = write_flag && (write_addr == RegEpc);
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] div_q, div_d;

    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        div_d     = div_q;
        ti_d      = cause_q[30];
        // A Count write restarts the divider, so the next tick is a full period away.
        if (wr_count) begin
            count_d = write_data;
            div_d   = '0;
        end else if (div_q == 32'(COUNT_DIV - 1)) begin
            count_d = count_q + 32'd1;
            div_d   = '0;
        end else begin
            div_d = div_q + 32'd1;
        end
        if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
        // Compare write acknowledges the timer and beats a same-cycle match.
        if (wr_compare) begin
            compare_d = write_data;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            div_q     <= '0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            div_q     <= div_d;
        end
    end

    assign count_rd   = count_q;
    assign compare_rd = compare_q;
`else
    assign ti_d       = 1'b0;
    assign count_rd   = '0;
    assign compare_rd = '0;
`endif

    // Update order mirrors priority: sampling, then MTC0, then exception/ERET on top.
    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        cause_d[30]    = ti_d;
        cause_d[15:10] = {hw_int[5] | ti_d, hw_int[4:0]};

        if (wr_status) begin
            status_d = StatusBev | (write_data & StatusWMask);
        end
        if (wr_cause) begin
            cause_d[9:8] = write_data[9:8];
        end
        if (wr_epc) begin
            epc_d = write_data;
        end

        exl_merged = status_d[1];

        if (exc_flag) begin
            if (!exl_merged) begin
                epc_d       = exc_delayslot ? exc_pc - 32'd4 : exc_pc;
                cause_d[31] = exc_delayslot;
            end
            status_d[1]  = 1'b1;
            cause_d[6:2] = exc_code;
            if ((exc_code == 5'd4) || (exc_code == 5'd5)) begin
                badvaddr_d = exc_badvaddr;
            end
        end else if (eret_flag) begin
            status_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        read_data = '0;
        case (read_addr)
            RegBadVAddr: read_data = badvaddr_q;
            RegCount:    read_data = count_rd;
            RegCompare:  read_data = compare_rd;
            RegStatus:   read_data = status_q;
            RegCause:    read_data = cause_q;
            RegEpc:      read_data = epc_q;
            default:     read_data = '0;
        endcase
    end

    assign status      = status_q;
    assign cause       = cause_q;
    assign epc         = epc_q;
    assign timer_int   = cause_q[30];
    assign int_pending = status_q[0] & ~status_q[1] & (|(cause_q[15:8] & status_q[15:8]));

endmodule

// File: tb/tb_cp0_regfile.sv
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hw_int;
    logic        write_flag;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [4:0]  read_addr;
    logic        exc_flag;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_delayslot;
    logic [31:0] exc_badvaddr;
    logic        eret_flag;
    logic [31:0] read_data;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        timer_int;
    logic        int_pending;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cp0_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .hw_int       (hw_int),
        .write_flag   (write_flag),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_addr    (read_addr),
        .exc_flag     (exc_flag),
        .exc_code     (exc_code),
        .exc_pc       (exc_pc),
        .exc_delayslot(exc_delayslot),
        .exc_badvaddr (exc_badvaddr),
        .eret_flag    (eret_flag),
        .read_data    (read_data),
        .status       (status),
        .cause        (cause),
        .epc          (epc),
        .timer_int    (timer_int),
        .int_pending  (int_pending)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        write_flag = 1'b1;
        write_addr = addr;
        write_data = data;
        step();
        write_flag = 1'b0;
    endtask

    task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                             input logic [31:0] bva);
        exc_flag      = 1'b1;
        exc_code      = code;
        exc_pc        = pc;
        exc_delayslot = ds;
        exc_badvaddr  = bva;
        step();
        exc_flag = 1'b0;
    endtask

    task automatic do_eret();
        eret_flag = 1'b1;
        step();
        eret_flag = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        read_addr = 5'd9;
        #1;
        n_tests++;
        if (status !== 32'h0040_0000) begin
            n_fail++; $display("FAIL reset_status got %h want %h", status, 32'h0040_0000);
        end
        n_tests++;
        if (cause !== 32'h0 || epc !== 32'h0) begin
            n_fail++; $display("FAIL reset_cause_epc got %h/%h want 0/0", cause, epc);
        end
        n_tests++;
        if (read_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_count got %h want 0", read_data);
        end
        n_tests++;
        if (int_pending !== 1'b0 || timer_int !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got %b%b want 00", int_pending, timer_int);
        end
    endtask

    task automatic test_timer();
`ifdef CP0_TIMER_EN
        int waited;
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd6);
        n_tests++;
        if (timer_int !== 1'b0) begin
            n_fail++; $display("FAIL timer_cleared_by_compare got %b want 0", timer_int);
        end
        waited = 0;
        while (timer_int !== 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        n_tests++;
        if (timer_int !== 1'b1 || waited < 10 || waited > 14) begin
            n_fail++; $display("FAIL timer_fire got ti=%b after %0d cycles want 1 after ~12",
                               timer_int, waited);
        end
        n_tests++;
        if (cause[15] !== 1'b1) begin
            n_fail++; $display("FAIL timer_ip7 got %b want 1", cause[15]);
        end
        mtc0(5'd11, 32'd0);
        n_tests++;
        if (timer_int !== 1'b0) begin
            n_fail++; $display("FAIL timer_ack got %b want 0", timer_int);
        end
`else
        mtc0(5'd9, 32'd5);
        mtc0(5'd11, 32'd5);
        step();
        step();
        read_addr = 5'd9;
        #1;
        n_tests++;
        if (read_data !== 32'h0) begin
            n_fail++; $display("FAIL timer_off_count got %h want 0", read_data);
        end
        read_addr = 5'd11;
        #1;
        n_tests++;
        if (read_data !== 32'h0) begin
            n_fail++; $display("FAIL timer_off_compare got %h want 0", read_data);
        end
        n_tests++;
        if (timer_int !== 1'b0 || cause !== 32'h0) begin
            n_fail++; $display("FAIL timer_off_ti got ti=%b cause=%h want 0/0", timer_int, cause);
        end
`endif
    endtask

    task automatic test_status_cause_write();
        mtc0(5'd12, 32'hFFFF_FFFF);
        read_addr = 5'd12;
        #1;
        n_tests++;
        if (status !== 32'h0040_FF03 || read_data !== 32'h0040_FF03) begin
            n_fail++; $display("FAIL status_mask got %h/%h want 0040ff03", status, read_data);
        end
        mtc0(5'd13, 32'hFFFF_FFFF);
        n_tests++;
        if (cause !== 32'h0000_0300 || int_pending !== 1'b0) begin
            n_fail++; $display("FAIL cause_mask got %h ip=%b want 00000300 ip=0",
                               cause, int_pending);
        end
        mtc0(5'd12, 32'h0000_0301);
        n_tests++;
        if (status !== 32'h0040_0301 || int_pending !== 1'b1) begin
            n_fail++; $display("FAIL soft_int got %h ip=%b want 00400301 ip=1",
                               status, int_pending);
        end
        mtc0(5'd8, 32'hDEAD_BEEF);
        read_addr = 5'd8;
        #1;
        n_tests++;
        if (read_data !== 32'h0) begin
            n_fail++; $display("FAIL badvaddr_ro got %h want 0", read_data);
        end
        read_addr = 5'd3;
        #1;
        n_tests++;
        if (read_data !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_read got %h want 0", read_data);
        end
        mtc0(5'd13, 32'h0);
        mtc0(5'd12, 32'h0);
    endtask

    task automatic test_exception();
        raise_exc(5'd4, 32'hBFC0_0104, 1'b1, 32'h0000_1235);
        read_addr = 5'd8;
        #1;
        n_tests++;
        if (epc !== 32'hBFC0_0100 || cause !== 32'h8000_0010) begin
            n_fail++; $display("FAIL exc_first got epc=%h cause=%h want bfc00100/80000010",
                               epc, cause);
        end
        n_tests++;
        if (read_data !== 32'h0000_1235 || status !== 32'h0040_0002) begin
            n_fail++; $display("FAIL exc_badvaddr got bva=%h st=%h want 00001235/00400002",
                               read_data, status);
        end
        raise_exc(5'd12, 32'h8000_0200, 1'b0, 32'h0000_9999);
        #1;
        n_tests++;
        if (epc !== 32'hBFC0_0100 || cause !== 32'h8000_0030 || read_data !== 32'h0000_1235) begin
            n_fail++; $display("FAIL exc_nested got epc=%h cause=%h bva=%h want bfc00100/80000030/00001235",
                               epc, cause, read_data);
        end
        do_eret();
        n_tests++;
        if (status !== 32'h0040_0000 || epc !== 32'hBFC0_0100) begin
            n_fail++; $display("FAIL eret got st=%h epc=%h want 00400000/bfc00100", status, epc);
        end
    endtask

    task automatic test_mtc0_vs_exception();
        // EPC write in the same cycle as an exception loses to the exception.
        write_flag = 1'b1; write_addr = 5'd14; write_data = 32'h1111_0000;
        raise_exc(5'd8, 32'h0000_0400, 1'b0, 32'h0);
        write_flag = 1'b0;
        n_tests++;
        if (epc !== 32'h0000_0400 || cause !== 32'h0000_0020 || status !== 32'h0040_0002) begin
            n_fail++; $display("FAIL exc_beats_epc_write got epc=%h cause=%h st=%h want 00000400/00000020/00400002",
                               epc, cause, status);
        end
        do_eret();
        // Same-cycle Status write setting EXL makes the exception see EXL=1.
        write_flag = 1'b1; write_addr = 5'd12; write_data = 32'h0000_0002;
        raise_exc(5'd10, 32'h0000_0500, 1'b1, 32'h0);
        write_flag = 1'b0;
        n_tests++;
        if (epc !== 32'h0000_0400 || cause !== 32'h0000_0028 || status !== 32'h0040_0002) begin
            n_fail++; $display("FAIL merged_exl got epc=%h cause=%h st=%h want 00000400/00000028/00400002",
                               epc, cause, status);
        end
        do_eret();
    endtask

    task automatic test_interrupt();
        hw_int = 6'b000001;
        mtc0(5'd12, 32'h0040_0401);
        n_tests++;
        if (cause !== 32'h0000_0428 || int_pending !== 1'b1 || status !== 32'h0040_0401) begin
            n_fail++; $display("FAIL hw_int got cause=%h ip=%b st=%h want 00000428/1/00400401",
                               cause, int_pending, status);
        end
        eret_flag = 1'b1;
        raise_exc(5'd0, 32'h0000_0600, 1'b0, 32'h0);
        eret_flag = 1'b0;
        n_tests++;
        if (status !== 32'h0040_0403 || epc !== 32'h0000_0600 || int_pending !== 1'b0) begin
            n_fail++; $display("FAIL exc_and_eret got st=%h epc=%h ip=%b want 00400403/00000600/0",
                               status, epc, int_pending);
        end
        hw_int = 6'b0;
    endtask

    task automatic test_reset_midrun();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (status !== 32'h0040_0000 || cause !== 32'h0 || epc !== 32'h0) begin
            n_fail++; $display("FAIL midrun_reset got st=%h cause=%h epc=%h want 00400000/0/0",
                               status, cause, epc);
        end
    endtask

    initial begin
        rst = 1'b0; hw_int = '0; write_flag = 1'b0; write_addr = '0; write_data = '0;
        read_addr = '0; exc_flag = 1'b0; exc_code = '0; exc_pc = '0; exc_delayslot = 1'b0;
        exc_badvaddr = '0; eret_flag = 1'b0;
        #2;
        test_reset();
        test_timer();
        test_status_cause_write();
        test_exception();
        test_mtc0_vs_exception();
        test_interrupt();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
